// File: rtl/alu_decode_pkg.sv
// Shared encodings for the decode unit: opcodes, funct codes, ALU classes and
// ALU control codes, plus the immediate sign-extension helper.
package alu_decode_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [3:0] CTR_AND  = 4'b0000;
  localparam logic [3:0] CTR_OR   = 4'b0001;
  localparam logic [3:0] CTR_ADD  = 4'b0010;
  localparam logic [3:0] CTR_SUB  = 4'b0110;
  localparam logic [3:0] CTR_SLT  = 4'b0111;
  localparam logic [3:0] CTR_SLL  = 4'b1000;
  localparam logic [3:0] CTR_SRL  = 4'b1001;
  localparam logic [3:0] CTR_NOR  = 4'b1100;
  localparam logic [3:0] CTR_NONE = 4'b1111;

  function automatic logic signed [DATA_W-1:0] sign_ext(input logic [15:0] imm);
    return {{(DATA_W-16){imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/alu_core.sv
// 32-bit combinational ALU; unknown control codes yield zero.
module alu_core
  import alu_decode_pkg::*;
(
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic        [REG_W-1:0]  shamt,
  input  logic        [3:0]        ctr,
  output logic        [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (ctr)
      CTR_AND: result = a & b;
      CTR_OR:  result = a | b;
      CTR_ADD: result = a + b;
      CTR_SUB: result = a - b;
      CTR_NOR: result = ~(a | b);
      CTR_SLT: result = {{(DATA_W-1){1'b0}}, (a < b)};
      CTR_SLL: result = b << shamt;
      CTR_SRL: result = $unsigned(b) >> shamt;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_decode_unit.sv
// Single-cycle main decode + ALU control + ALU, all outputs registered once.
// Define ALU_SHIFT_EN to enable the sll/srl funct codes.
module alu_decode_unit
  import alu_decode_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] inst,
  input  logic [DATA_W-1:0] src_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [1:0]        alu_op,
  output logic              reg_dst,
  output logic              reg_wrt,
  output logic              mem_read,
  output logic              mem_wrt,
  output logic              mem_reg,
  output logic              alu_src,
  output logic              branch,
  output logic              jump,
  output logic [REG_W-1:0]  rs,
  output logic [REG_W-1:0]  rt,
  output logic [REG_W-1:0]  rd,
  output logic [REG_W-1:0]  shamt,
  output logic [5:0]        funct,
  output logic [3:0]        alu_ctr,
  output logic [DATA_W-1:0] alu_out,
  output logic              zf
);

  logic [1:0] alu_op_p0;
  logic reg_dst_p0, reg_wrt_p0, mem_read_p0, mem_wrt_p0;
  logic mem_reg_p0, alu_src_p0, branch_p0, jump_p0;
  logic [3:0] alu_ctr_p0;
  logic signed [DATA_W-1:0] opb_p0;
  logic [DATA_W-1:0] result_p0;

  // Stage p0: combinational decode and execute
  always_comb begin
    alu_op_p0   = ALUOP_ADD;
    reg_dst_p0  = 1'b0;
    reg_wrt_p0  = 1'b0;
    mem_read_p0 = 1'b0;
    mem_wrt_p0  = 1'b0;
    mem_reg_p0  = 1'b0;
    alu_src_p0  = 1'b0;
    branch_p0   = 1'b0;
    jump_p0     = 1'b0;
    case (inst[31:26])
      OP_RTYPE: begin reg_dst_p0 = 1'b1; reg_wrt_p0 = 1'b1; alu_op_p0 = ALUOP_RTYPE; end
      OP_LW: begin
        alu_src_p0 = 1'b1; mem_reg_p0 = 1'b1; reg_wrt_p0 = 1'b1; mem_read_p0 = 1'b1;
      end
      OP_SW:    begin alu_src_p0 = 1'b1; mem_wrt_p0 = 1'b1; end
      OP_BEQ:   begin branch_p0 = 1'b1; alu_op_p0 = ALUOP_SUB; end
      OP_ADDI:  begin alu_src_p0 = 1'b1; reg_wrt_p0 = 1'b1; end
      OP_J:     jump_p0 = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    alu_ctr_p0 = CTR_ADD;
    case (alu_op_p0)
      ALUOP_SUB: alu_ctr_p0 = CTR_SUB;
      ALUOP_RTYPE: begin
        case (inst[5:0])
          FN_ADD:  alu_ctr_p0 = CTR_ADD;
          FN_SUB:  alu_ctr_p0 = CTR_SUB;
          FN_AND:  alu_ctr_p0 = CTR_AND;
          FN_OR:   alu_ctr_p0 = CTR_OR;
          FN_NOR:  alu_ctr_p0 = CTR_NOR;
          FN_SLT:  alu_ctr_p0 = CTR_SLT;
`ifdef ALU_SHIFT_EN
          FN_SLL:  alu_ctr_p0 = CTR_SLL;
          FN_SRL:  alu_ctr_p0 = CTR_SRL;
`endif
          default: alu_ctr_p0 = CTR_NONE;
        endcase
      end
      default: alu_ctr_p0 = CTR_ADD;
    endcase
  end

  assign opb_p0 = alu_src_p0 ? sign_ext(inst[15:0]) : $signed(rt_data);

  alu_core u_alu_core (
    .a      ($signed(src_data)),
    .b      (opb_p0),
    .shamt  (inst[10:6]),
    .ctr    (alu_ctr_p0),
    .result (result_p0)
  );

  // Stage p1: output registers; reset clears everything including the datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op   <= '0;
      reg_dst  <= 1'b0;
      reg_wrt  <= 1'b0;
      mem_read <= 1'b0;
      mem_wrt  <= 1'b0;
      mem_reg  <= 1'b0;
      alu_src  <= 1'b0;
      branch   <= 1'b0;
      jump     <= 1'b0;
      rs       <= '0;
      rt       <= '0;
      rd       <= '0;
      shamt    <= '0;
      funct    <= '0;
      alu_ctr  <= '0;
      alu_out  <= '0;
      zf       <= 1'b0;
    end else begin
      alu_op   <= alu_op_p0;
      reg_dst  <= reg_dst_p0;
      reg_wrt  <= reg_wrt_p0;
      mem_read <= mem_read_p0;
      mem_wrt  <= mem_wrt_p0;
      mem_reg  <= mem_reg_p0;
      alu_src  <= alu_src_p0;
      branch   <= branch_p0;
      jump     <= jump_p0;
      rs       <= inst[25:21];
      rt       <= inst[20:16];
      rd       <= inst[15:11];
      shamt    <= inst[10:6];
      funct    <= inst[5:0];
      alu_ctr  <= alu_ctr_p0;
      alu_out  <= result_p0;
      zf       <= (result_p0 == '0);
    end
  end

endmodule

// File: tb/tb_alu_decode_unit.sv
// Directed and randomized bench for alu_decode_unit against a spec-level model.
module tb_alu_decode_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = '0, src_data = '0, rt_data = '0;
  logic [1:0]  alu_op;
  logic        reg_dst, reg_wrt, mem_read, mem_wrt, mem_reg, alu_src, branch, jump;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [3:0]  alu_ctr;
  logic [31:0] alu_out;
  logic        zf;

  int vectors = 0;
  int miscompares = 0;

  alu_decode_unit dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .src_data(src_data), .rt_data(rt_data),
    .alu_op(alu_op), .reg_dst(reg_dst), .reg_wrt(reg_wrt), .mem_read(mem_read),
    .mem_wrt(mem_wrt), .mem_reg(mem_reg), .alu_src(alu_src), .branch(branch),
    .jump(jump), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .alu_ctr(alu_ctr), .alu_out(alu_out), .zf(zf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  alu_op;
    logic [7:0]  strobes;   // reg_dst,reg_wrt,mem_read,mem_wrt,mem_reg,alu_src,branch,jump
    logic [3:0]  alu_ctr;
    logic [31:0] alu_out;
    logic        zf;
  } exp_t;

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] a, input logic [31:0] r);
    exp_t e;
    logic [31:0] b;
    int sh;
    e = '0;
    case (i[31:26])
      6'd0:  begin e.strobes = 8'b1100_0000; e.alu_op = 2'd2; end
      6'd35: e.strobes = 8'b0110_1100;
      6'd43: e.strobes = 8'b0001_0100;
      6'd4:  begin e.strobes = 8'b0000_0010; e.alu_op = 2'd1; end
      6'd8:  e.strobes = 8'b0100_0100;
      6'd2:  e.strobes = 8'b0000_0001;
      default: ;
    endcase
    b  = e.strobes[2] ? {{16{i[15]}}, i[15:0]} : r;
    sh = int'(i[10:6]);
    if (e.alu_op == 2'd1) begin
      e.alu_ctr = 4'd6; e.alu_out = a - b;
    end else if (e.alu_op == 2'd2) begin
      case (i[5:0])
        6'd32: begin e.alu_ctr = 4'd2;  e.alu_out = a + b; end
        6'd34: begin e.alu_ctr = 4'd6;  e.alu_out = a - b; end
        6'd36: begin e.alu_ctr = 4'd0;  e.alu_out = a & b; end
        6'd37: begin e.alu_ctr = 4'd1;  e.alu_out = a | b; end
        6'd39: begin e.alu_ctr = 4'd12; e.alu_out = ~(a | b); end
        6'd42: begin e.alu_ctr = 4'd7;  e.alu_out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
`ifdef ALU_SHIFT_EN
        6'd0:  begin e.alu_ctr = 4'd8;  e.alu_out = r << sh; end
        6'd2:  begin e.alu_ctr = 4'd9;  e.alu_out = r >> sh; end
`endif
        default: begin e.alu_ctr = 4'd15; e.alu_out = 32'd0; end
      endcase
    end else begin
      e.alu_ctr = 4'd2; e.alu_out = a + b;
    end
    e.zf = (e.alu_out == 32'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] i, input logic [31:0] a,
                           input logic [31:0] r);
    exp_t e;
    e = model(i, a, r);
    chk({tag, ".alu_op"},  32'(alu_op), 32'(e.alu_op));
    chk({tag, ".strobes"}, 32'({reg_dst, reg_wrt, mem_read, mem_wrt, mem_reg, alu_src, branch, jump}),
        32'(e.strobes));
    chk({tag, ".fields"},  {6'd0, rs, rt, rd, shamt, funct}, {6'd0, i[25:0]});
    chk({tag, ".alu_ctr"}, 32'(alu_ctr), 32'(e.alu_ctr));
    chk({tag, ".alu_out"}, alu_out, e.alu_out);
    chk({tag, ".zf"},      32'(zf), 32'(e.zf));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".ctl"}, 32'({alu_op, reg_dst, reg_wrt, mem_read, mem_wrt, mem_reg, alu_src,
                            branch, jump, alu_ctr, zf}), 32'd0);
    chk({tag, ".fields"}, {6'd0, rs, rt, rd, shamt, funct}, 32'd0);
    chk({tag, ".alu_out"}, alu_out, 32'd0);
  endtask

  task automatic apply(input string tag, input logic [31:0] i, input logic [31:0] a,
                       input logic [31:0] r);
    inst = i; src_data = a; rt_data = r;
    vectors++;
    @(posedge clk);
    #1;
    check_all(tag, i, a, r);
  endtask

  logic [5:0] ops [7] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd2, 6'd0};
  logic [5:0] fns [9] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd0, 6'd2, 6'd0};

  initial begin
    logic [31:0] ri, ra, rr;
    inst = 32'h012A4020; src_data = 32'd5; rt_data = 32'd7;
    #1;
    check_zero("reset_initial");
    #12;
    rst_n = 1'b1;

    apply("add", 32'h012A4020, 32'd5, 32'd7);
    chk("add.alu_out_lit", alu_out, 32'd12);
    chk("add.rs_lit", 32'(rs), 32'd9);
    chk("add.rd_lit", 32'(rd), 32'd8);
    chk("add.ctr_lit", 32'(alu_ctr), 32'b0010);

    apply("beq", 32'h11090003, 32'h1234, 32'h1234);
    chk("beq.zf_lit", 32'(zf), 32'd1);
    chk("beq.branch_lit", 32'(branch), 32'd1);

    apply("lw", 32'h8D28FFFC, 32'h100, 32'hDEAD_BEEF);
    chk("lw.alu_out_lit", alu_out, 32'hFC);
    chk("lw.mem_read_lit", 32'(mem_read), 32'd1);

    apply("slt", 32'h012A402A, 32'hFFFF_FFFF, 32'd1);
    chk("slt.alu_out_lit", alu_out, 32'd1);

    apply("shift", 32'h00094080, 32'd0, 32'd3);
`ifdef ALU_SHIFT_EN
    chk("shift.alu_out_lit", alu_out, 32'd12);
`else
    chk("shift.alu_out_lit", alu_out, 32'd0);
    chk("shift.zf_lit", 32'(zf), 32'd1);
`endif

    apply("nop_op", 32'hFC00_1234, 32'd1, 32'd2);
    apply("sw", 32'hAD28_0010, 32'h40, 32'h5);
    apply("addi_neg", 32'h2128_8000, 32'h0, 32'h0);
    apply("sub_wrap", 32'h012A4022, 32'd0, 32'd1);

    // Mid-stream reset between edges
    apply("pre_reset", 32'h012A4020, 32'd5, 32'd7);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid");
    #1;
    rst_n = 1'b1;
    #1;
    check_zero("reset_released");
    @(posedge clk);
    #1;
    vectors++;
    check_all("post_reset", 32'h012A4020, 32'd5, 32'd7);

    for (int n = 0; n < 300; n++) begin
      ri = $urandom;
      ri[31:26] = (($urandom % 8) == 7) ? 6'($urandom) : ops[$urandom % 7];
      if (($urandom % 3) != 0) ri[5:0] = fns[$urandom % 9];
      ra = $urandom;
      rr = (($urandom % 4) == 0) ? ra : $urandom;
      apply("rand", ri, ra, rr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_decode_unit.md
ALU_DECODE_UNIT -- requirements
Module: alu_decode_unit

Interface
REQ-001 SHALL have no parameters; datapath width is fixed at 32 bits, register index width at 5 bits.
REQ-002 SHALL use one clock and an asynchronous, active-low reset, with the ports named clk and rst_n.
REQ-003 clk  input  1  rising-edge clock; all outputs are registered on it.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 inst  input  32  instruction word: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [5:0], imm16 [15:0].
REQ-006 src_data  input  32  ALU operand A (rs register value).
REQ-007 rt_data  input  32  rt register value; this is operand B when alu_src=0.
REQ-008 alu_op  output  2  main-decoder ALU class: 00 add, 01 sub, 10 R-type.
REQ-009 reg_dst, reg_wrt, mem_read, mem_wrt, mem_reg, alu_src, branch, jump  output  1 each  control strobes.
REQ-010 rs, rt, rd, shamt  output  5 each; funct  output  6.  Fields split from inst.
REQ-011 alu_ctr  output  4  ALU operation code.
REQ-012 alu_out  output  32  ALU result; zf  output  1  high when alu_out == 0.

Function
REQ-013 SHALL decode the inputs combinationally and register every output on the rising edge of clk, giving a latency of exactly 1 cycle from inputs to outputs.
REQ-014 Opcode 000000 (R-type) SHALL set reg_dst=1, reg_wrt=1, alu_op=10.
REQ-015 Opcode 100011 (lw) SHALL set alu_src=1, mem_reg=1, reg_wrt=1, mem_read=1, alu_op=00.
REQ-016 Opcode 101011 (sw) SHALL set alu_src=1, mem_wrt=1, alu_op=00.
REQ-017 Opcode 000100 (beq) SHALL set branch=1, alu_op=01.
REQ-018 Opcode 001000 (addi) SHALL set alu_src=1, reg_wrt=1, alu_op=00.
REQ-019 Opcode 000010 (j) SHALL set jump=1.
REQ-020 Any other opcode SHALL drive all strobes to 0 and alu_op to 00, i.e. behave as a nop.
REQ-021 Strobes not named for an opcode SHALL be 0 for that opcode.
REQ-022 alu_op 00 SHALL map to alu_ctr 0010 (add).
REQ-023 alu_op 01 SHALL map to alu_ctr 0110 (sub).
REQ-024 alu_op 11 is reserved and SHALL map to alu_ctr 0010 (add).
REQ-025 alu_op 10 SHALL map on funct: 100000→0010 add, 100010→0110 sub, 100100→0000 and, 100101→0001 or, 100111→1100 nor, 101010→0111 slt.
REQ-026 Any other funct under alu_op 10 SHALL map to alu_ctr 1111, which gives alu_out=0.
REQ-027 Operand B SHALL be the sign-extended imm16 when alu_src=1, and rt_data otherwise.
REQ-028 add and sub SHALL wrap modulo 2^32; there is no overflow or carry output.
REQ-029 slt SHALL be a signed compare producing 1 or 0 in bit 0, with the upper bits 0.
REQ-030 zf SHALL be computed from the same cycle's result and registered together with alu_out.

Reset
REQ-031 While rst_n=0, every output SHALL be 0 immediately, with no dependence on clk.
REQ-032 After rst_n is released, the first rising edge of clk SHALL register the current decode result.
REQ-033 Asserting reset mid-stream SHALL discard the in-flight result.

Configuration
REQ-034 With ALU_SHIFT_EN defined, funct 000000 SHALL map to alu_ctr 1000, giving alu_out = rt_data << shamt.
REQ-035 With ALU_SHIFT_EN defined, funct 000010 SHALL map to alu_ctr 1001, giving alu_out = rt_data >> shamt (logical).
REQ-036 Without ALU_SHIFT_EN, funct 000000 and funct 000010 SHALL map to 1111, giving alu_out=0 and zf=1.

Structure
REQ-037 The opcode, funct, alu_op and alu_ctr encodings SHALL be defined as constants in the shared package alu_decode_pkg.
REQ-038 The 32-bit ALU datapath SHALL be a sub-module named alu_core; main decode and ALU-control decode SHALL be inline in the top module.

Verification
REQ-039 Add: inst=0x012A4020, src_data=5, rt_data=7 → after 1 edge: rs=9, rt=10, rd=8, funct=0x20, alu_ctr=0010, alu_out=12, zf=0, reg_dst=1, reg_wrt=1.
REQ-040 beq: inst=0x11090003, src_data=rt_data=0x1234 → branch=1, alu_op=01, alu_ctr=0110, alu_out=0, zf=1.
REQ-041 lw with sign extension: inst=0x8D28FFFC, src_data=0x100 → alu_out=0xFC, mem_read=1, mem_reg=1, alu_src=1, reg_wrt=1.
REQ-042 slt: inst=0x012A402A, src_data=0xFFFFFFFF, rt_data=1 → alu_out=1, zf=0.
REQ-043 Shift: inst=0x00094080, rt_data=3 → alu_out=12 with ALU_SHIFT_EN defined; alu_out=0 and zf=1 without it.
REQ-044 Reset: drive the add case of REQ-039, then pull rst_n low between edges → all outputs 0 at once; release → values return after the next edge.
